vmem_arbiter: RTL and testbench
===============================

Name: vmem_arbiter

Overview:
- Sole owner of the single-port frame-buffer RAM: 2^19 x 24-bit, synchronous read, 1-cycle latency.
- Shares the RAM between three users:
  - the VGA scanout read path (vga_ctrl pixel fetch);
  - a buffered pixel-write requester (keyboard/CPU drawing logic);
  - an internal clear engine that fills the visible 640x480 area with one colour.
- Scanout always wins.
- Writes and clears use only the cycles where scanout does not request.

Parameters:
- AW, 19, RAM address width; address = {h[9:0], v[8:0]}.
- DW, 24, pixel width, RGB888.
- FIFO_DEPTH, 4, write-buffer entries; power of two, >=2.
- H_RES, 640, clear-engine horizontal extent.
- V_RES, 480, clear-engine vertical extent.

Ports:
- clock  in  1  system/pixel clock.
- resetn  in  1  synchronous, active-low reset.
- sc_req  in  1  scanout read request this cycle.
- sc_addr  in  AW  scanout address {h_addr, v_addr[8:0]}.
- sc_data  out  DW  read data, valid when sc_rvalid.
- sc_rvalid  out  1  sc_req delayed one cycle.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write pixel.
- clr_start  in  1  one-cycle clear command.
- clr_color  in  DW  fill colour, sampled on clr_start acceptance.
- clr_busy  out  1  clear sequence in progress (DRAIN or CLEAR).
- clr_done  out  1  one-cycle pulse after the last clear write.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, one cycle after the address.
- stat_stall  out  16  write-stall counter (optional feature).

Behaviour:
- Reset (resetn=0 at clock edge):
  - state IDLE, FIFO emptied, clear pointer (h,v)=(0,0).
  - sc_rvalid=0, clr_busy=0, clr_done=0, stat_stall=0.
  - In-flight clear is abandoned; the RAM is not touched.
- RAM-port grant, combinational, evaluated every cycle in this priority order:
  1. sc_req=1: mem_addr=sc_addr, mem_we=0.
  2. state CLEAR: mem_addr={clr_h, clr_v}, mem_we=1, mem_wdata=clr_color_q.
  3. FIFO non-empty: mem_addr and mem_wdata from the FIFO head, mem_we=1, head popped.
  4. Otherwise: mem_we=0, mem_addr=0, mem_wdata=0.
- While resetn=0: mem_we=0, mem_addr=0, mem_wdata=0.
- Scanout read path:
  - sc_data = mem_rdata (pass-through).
  - sc_rvalid is a register = sc_req of the previous cycle.
  - Read latency is exactly 1 cycle, independent of the write load.
- Write FIFO:
  - wr_ready = (state==IDLE) && !full.
  - Push on wr_valid && wr_ready. No same-cycle bypass: an accepted entry can reach the RAM at the earliest on the next cycle.
  - Push and pop in the same cycle is legal; occupancy is unchanged.
  - Entries are written in acceptance order. No coalescing of writes to the same address.
- State machine:
  - IDLE: clr_start=1 latches clr_color into clr_color_q and moves to DRAIN; clr_busy=1 from the next cycle.
  - DRAIN: wr_ready=0. When the FIFO is empty, move to CLEAR with the pointer at (0,0).
  - CLEAR: each granted cycle (sc_req=0) writes one pixel and advances the pointer. h increments; at h=H_RES-1, h wraps to 0 and v increments. A stalled cycle holds the pointer.
  - Leaving CLEAR: the cycle that writes (H_RES-1, V_RES-1) moves to IDLE. clr_done=1 on the following cycle; clr_busy=0 on that same cycle.
- clr_start is ignored when state != IDLE.
- Total clear length is H_RES*V_RES granted cycles; unbounded while sc_req stays high (no starvation protection).
- Pixels outside H_RES x V_RES are never written by the clear engine.

Optional Feature:
- Macro: VMEM_ARB_STATS_EN.
- Defined: stat_stall is a 16-bit saturating counter (stops at 16'hFFFF). It increments each cycle where sc_req=1 and the FIFO is non-empty or state==CLEAR. Reset to 0.
- Undefined: stat_stall is tied to 0 and no counter logic is synthesised.

Decomposition:
- Package vmem_pkg:
  - VMEM_AW, VMEM_DW.
  - Address-pack function vmem_addr(h,v) -> {h[9:0], v[8:0]}.
  - Typedef arb_state_t {IDLE, DRAIN, CLEAR}.
  - Struct wr_req_t {addr, data}.
- One sub-module: vmem_wr_fifo, a synchronous FIFO of wr_req_t with parameter FIFO_DEPTH. Ports: push/pop/full/empty/head; synchronous active-low reset.

Test Plan:
- Scanout only:
  - Stimulus: sc_req=1 continuously, sc_addr stepping 0,1,2..; RAM preloaded.
  - Required: sc_data/sc_rvalid match RAM[addr] exactly 1 cycle later; mem_we never 1.
- Write under load:
  - Stimulus: sc_req=1 while 5 writes are offered (addr 0x00010..0x00014, data 0xFF0000+i).
  - Required: 4 writes accepted, wr_ready=0 on the 5th; no mem_we while sc_req=1.
  - Then sc_req=0: writes land in order on consecutive cycles; the 5th is accepted once the FIFO has space.
- Clear sequence:
  - Stimulus: clr_start with clr_color=0x00FF00, sc_req=0, FIFO holding 2 entries.
  - Required: both entries written first, then 307200 clear writes.
  - Last clear write is at {10'd639, 9'd479}; clr_done pulses once; address {10'd640, 9'd0} is never written.
- Clear stalled:
  - Stimulus: toggle sc_req 1/0 every cycle during CLEAR.
  - Required: the pointer advances only on sc_req=0 cycles; total clear writes still 307200.
  - A second clr_start while clr_busy=1 is ignored (exactly one clr_done).
- Reset mid-clear:
  - Stimulus: drop resetn for 1 cycle at pointer (100,5).
  - Required: state IDLE, clr_busy=0, clr_done never pulses, FIFO empty, wr_ready=1 on the next cycle.
- Stats (VMEM_ARB_STATS_EN):
  - Stimulus: FIFO non-empty, sc_req=1 for 70000 cycles.
  - Required: stat_stall saturates at 16'hFFFF.
  - Without the macro, stat_stall=0 throughout.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared types for the frame-buffer arbiter: widths, pixel address packing,
// arbiter state encoding and the buffered write request.
package vmem_pkg;
  localparam int VMEM_AW = 19;
  localparam int VMEM_DW = 24;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} arb_state_t;

  typedef struct packed {
    logic [VMEM_AW-1:0] addr;
    logic [VMEM_DW-1:0] data;
  } wr_req_t;

  function automatic logic [VMEM_AW-1:0] vmem_addr(input logic [9:0] h, input logic [8:0] v);
    return {h, v};
  endfunction
endpackage

// File: rtl/vmem_arbiter_if.sv
// User-side bundle of the arbiter: scanout, write port, clear control, RAM port.
// slave = arbiter view, master = the surrounding logic / RAM view.
interface vmem_arbiter_if;
  import vmem_pkg::*;

  logic               sc_req;
  logic [VMEM_AW-1:0] sc_addr;
  logic [VMEM_DW-1:0] sc_data;
  logic               sc_rvalid;
  logic               wr_valid;
  logic               wr_ready;
  logic [VMEM_AW-1:0] wr_addr;
  logic [VMEM_DW-1:0] wr_data;
  logic               clr_start;
  logic [VMEM_DW-1:0] clr_color;
  logic               clr_busy;
  logic               clr_done;
  logic [VMEM_AW-1:0] mem_addr;
  logic               mem_we;
  logic [VMEM_DW-1:0] mem_wdata;
  logic [VMEM_DW-1:0] mem_rdata;
  logic [15:0]        stat_stall;

  modport slave (
    input  sc_req, sc_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    output sc_data, sc_rvalid, wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_wdata, stat_stall
  );

  modport master (
    output sc_req, sc_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_rdata,
    input  sc_data, sc_rvalid, wr_ready, clr_busy, clr_done, mem_addr, mem_we, mem_wdata, stat_stall
  );
endinterface

// File: rtl/vmem_wr_fifo.sv
// Small synchronous FIFO buffering pixel writes until the RAM port is free.
module vmem_wr_fifo
  import vmem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic    clock,
  input  logic    resetn,
  input  logic    push,
  input  wr_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wr_req_t head
);
  localparam int PW = $clog2(FIFO_DEPTH);

  wr_req_t       r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  logic          w_push, w_pop;

  assign full   = (r_cnt == (PW+1)'(FIFO_DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/vmem_arbiter.sv
// Frame-buffer RAM owner: scanout reads always win; buffered writes and the
// fill-colour clear engine use idle cycles. VMEM_ARB_STATS_EN adds a stall counter.
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int AW         = VMEM_AW,
  parameter int DW         = VMEM_DW,
  parameter int FIFO_DEPTH = 4,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480
) (
  input  logic          clock,
  input  logic          resetn,
  vmem_arbiter_if.slave bus
);
  localparam logic [9:0] H_LAST = 10'(H_RES - 1);
  localparam logic [8:0] V_LAST = 9'(V_RES - 1);

  arb_state_t    r_state, w_state_nxt;
  logic [9:0]    r_h;
  logic [8:0]    r_v;
  logic [DW-1:0] r_clr_color;
  logic          r_rvalid, r_done;

  wr_req_t       w_head, w_push_req;
  logic          w_full, w_empty, w_push, w_pop;
  logic          w_clr_adv, w_clr_last;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic          w_mem_we;

  assign w_push_req = '{addr: bus.wr_addr, data: bus.wr_data};
  assign w_push     = bus.wr_valid && bus.wr_ready;
  assign w_clr_last = (r_h == H_LAST) && (r_v == V_LAST);

  vmem_wr_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock), .resetn(resetn),
    .push(w_push), .push_data(w_push_req), .pop(w_pop),
    .full(w_full), .empty(w_empty), .head(w_head)
  );

  assign bus.sc_data   = bus.mem_rdata;
  assign bus.sc_rvalid = r_rvalid;
  assign bus.wr_ready  = (r_state == IDLE) && !w_full;
  assign bus.clr_busy  = (r_state != IDLE);
  assign bus.clr_done  = r_done;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wdata = w_mem_wdata;

  // Port grant: scanout, then clear, then buffered writes; nothing while in reset.
  always_comb begin
    w_mem_addr  = '0;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    w_pop       = 1'b0;
    w_clr_adv   = 1'b0;
    if (!resetn) begin
      w_mem_we = 1'b0;
    end else if (bus.sc_req) begin
      w_mem_addr = bus.sc_addr;
    end else if (r_state == CLEAR) begin
      w_mem_addr  = vmem_addr(r_h, r_v);
      w_mem_we    = 1'b1;
      w_mem_wdata = r_clr_color;
      w_clr_adv   = 1'b1;
    end else if (!w_empty) begin
      w_mem_addr  = w_head.addr;
      w_mem_we    = 1'b1;
      w_mem_wdata = w_head.data;
      w_pop       = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.clr_start) w_state_nxt = DRAIN;
      DRAIN:   if (w_empty) w_state_nxt = CLEAR;
      CLEAR:   if (w_clr_adv && w_clr_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_h         <= '0;
      r_v         <= '0;
      r_clr_color <= '0;
      r_rvalid    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= bus.sc_req;
      r_done   <= w_clr_adv && w_clr_last;
      if (r_state == IDLE && bus.clr_start) r_clr_color <= bus.clr_color;
      if (r_state == DRAIN) begin
        r_h <= '0;
        r_v <= '0;
      end else if (w_clr_adv) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= r_v + 9'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

`ifdef VMEM_ARB_STATS_EN
  logic [15:0] r_stall;
  always_ff @(posedge clock) begin
    if (!resetn) r_stall <= '0;
    else if (bus.sc_req && (!w_empty || r_state == CLEAR) && r_stall != 16'hFFFF)
      r_stall <= r_stall + 16'd1;
  end
  assign bus.stat_stall = r_stall;
`else
  assign bus.stat_stall = '0;
`endif
endmodule

// File: tb/tb_vmem_arbiter.sv
// Scoreboard bench for vmem_arbiter on a reduced 16x6 clear area: stimulus pushes
// expected RAM writes / read returns, a negedge monitor pops and compares.
module tb_vmem_arbiter;
  import vmem_pkg::*;

  localparam int HR = 16;
  localparam int VR = 6;
  localparam int FD = 4;

  typedef struct { logic [18:0] a; logic [23:0] d; bit clr; bit last; } ew_t;
  typedef struct { int stamp; logic [23:0] d; } er_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  vmem_arbiter_if bus();

  vmem_arbiter #(.FIFO_DEPTH(FD), .H_RES(HR), .V_RES(VR)) dut (
    .clock(clock), .resetn(resetn), .bus(bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAM: untouched locations hold a address-derived pattern.
  logic [23:0] ram [int unsigned];
  function automatic logic [23:0] rd(input logic [18:0] a);
    if (ram.exists(32'(a))) return ram[32'(a)];
    return 24'(32'(a) * 7 + 32'h135);
  endfunction
  always @(posedge clock) begin
    bus.mem_rdata <= rd(bus.mem_addr);
    if (bus.mem_we) ram[32'(bus.mem_addr)] = bus.mem_wdata;
  end

  ew_t     wq[$];
  er_t     rq[$];
  wr_req_t src[$];
  int  pass_n = 0, fail_n = 0;
  bit  m_busy = 1'b0;
  int  exp_done_at = -1;
  int  done_n = 0, clr_wr_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act === exp) pass_n++;
    else begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    ew_t e;
    if (!resetn) begin
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
    end else begin
      chk("clr_busy", bus.clr_busy, m_busy);
      chk("wr_ready", bus.wr_ready, !m_busy && wq.size() < FD);
      chk("clr_done", bus.clr_done, cyc == exp_done_at);
      if (bus.clr_done) done_n++;
`ifndef VMEM_ARB_STATS_EN
      chk("stat_zero", bus.stat_stall, 0);
`endif
      if (bus.sc_req) begin
        chk("sc_no_write", bus.mem_we, 0);
        chk("sc_addr_fwd", bus.mem_addr, bus.sc_addr);
      end
      if (bus.mem_we) begin
        chk("write_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("write_addr", bus.mem_addr, e.a);
          chk("write_data", bus.mem_wdata, e.d);
          if (e.clr) clr_wr_n++;
          if (e.last) begin
            m_busy = 1'b0;
            exp_done_at = cyc + 1;
          end
        end
      end
    end
    if (rq.size() != 0 && rq[0].stamp == cyc - 1) begin
      chk("rvalid", bus.sc_rvalid, 1);
      chk("rdata", bus.sc_data, rq[0].d);
      void'(rq.pop_front());
    end else begin
      chk("rvalid_idle", bus.sc_rvalid, 0);
    end
  end

  // One clock of stimulus; records what the cycle committed to the model.
  task automatic tick();
    bit acc;
    wr_req_t w;
    if (!bus.wr_valid && src.size() != 0) begin
      w = src.pop_front();
      bus.wr_valid = 1'b1;
      bus.wr_addr  = w.addr;
      bus.wr_data  = w.data;
    end
    @(negedge clock); #1;
    acc = resetn && bus.wr_valid && bus.wr_ready;
    if (resetn) begin
      if (acc) wq.push_back('{a: bus.wr_addr, d: bus.wr_data, clr: 1'b0, last: 1'b0});
      if (bus.sc_req) rq.push_back('{stamp: cyc, d: rd(bus.sc_addr)});
      if (bus.clr_start && !m_busy) begin
        for (int v = 0; v < VR; v++)
          for (int h = 0; h < HR; h++)
            wq.push_back('{a: vmem_addr(10'(h), 9'(v)), d: bus.clr_color, clr: 1'b1,
                           last: (h == HR-1 && v == VR-1)});
        m_busy = 1'b1;
      end
    end else begin
      wq.delete();
      m_busy = 1'b0;
    end
    @(posedge clock); #1;
    bus.clr_start = 1'b0;
    if (acc) bus.wr_valid = 1'b0;
  endtask

  task automatic sc_tick(input bit sc, input logic [18:0] a);
    bus.sc_req  = sc;
    bus.sc_addr = a;
    tick();
  endtask

  task automatic wait_clear(input int bound);
    int k = 0;
    while (m_busy && k < bound) begin
      sc_tick(1'b0, '0);
      k++;
    end
    chk("clear_timeout", m_busy, 0);
  endtask

  initial begin
    int d0, c0, k;
    bus.sc_req = 0; bus.sc_addr = '0; bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.clr_start = 0; bus.clr_color = '0;
    tick(); tick();
    resetn = 1'b1;
    chk("reset_rvalid", bus.sc_rvalid, 0);
    chk("reset_busy", bus.clr_busy, 0);
    chk("reset_done", bus.clr_done, 0);
    chk("reset_wr_ready", bus.wr_ready, 1);
    chk("reset_stat", bus.stat_stall, 0);

    // Scanout only
    for (int i = 0; i < 16; i++) sc_tick(1'b1, 19'(i));

    // Write under load: 5 offered, 4 fit
    for (int i = 0; i < 5; i++) src.push_back('{addr: 19'(32'h10 + i), data: 24'(32'hFF0000 + i)});
    for (int i = 0; i < 8; i++) sc_tick(1'b1, 19'(32'h10 + i));
    chk("load_accepted", wq.size(), 4);
    chk("load_wr_ready", bus.wr_ready, 0);
    for (int i = 0; i < 10; i++) sc_tick(1'b0, '0);
    chk("load_drained", wq.size() + src.size() + 32'(bus.wr_valid), 0);
    for (int i = 0; i < 6; i++) sc_tick(1'b1, 19'(32'h10 + i));

    // Clear with 2 buffered writes ahead of it
    src.push_back('{addr: 19'h00123, data: 24'hABCDEF});
    src.push_back('{addr: 19'h00456, data: 24'h123456});
    for (int i = 0; i < 3; i++) sc_tick(1'b1, 19'(i));
    d0 = done_n; c0 = clr_wr_n;
    bus.clr_start = 1'b1; bus.clr_color = 24'h00FF00;
    sc_tick(1'b0, '0);
    wait_clear(HR*VR + 50);
    sc_tick(1'b0, '0); sc_tick(1'b0, '0);
    chk("clear_done_once", done_n - d0, 1);
    chk("clear_writes", clr_wr_n - c0, HR*VR);
    chk("clear_outside_untouched", rd(vmem_addr(10'(HR), 9'd0)), 24'(32'(vmem_addr(10'(HR), 9'd0)) * 7 + 32'h135));

    // Clear stalled by alternating scanout, second start ignored
    d0 = done_n; c0 = clr_wr_n;
    bus.clr_start = 1'b1; bus.clr_color = 24'h0000FF;
    sc_tick(1'b0, '0);
    k = 0;
    while (m_busy && k < 2*HR*VR + 100) begin
      if (k == 20) begin bus.clr_start = 1'b1; bus.clr_color = 24'hFFFFFF; end
      sc_tick(k[0], 19'($urandom_range(0, 200)));
      k++;
    end
    chk("stall_timeout", m_busy, 0);
    for (int i = 0; i < 4; i++) sc_tick(1'b0, '0);
    chk("stall_done_once", done_n - d0, 1);
    chk("stall_clr_writes", clr_wr_n - c0, HR*VR);

    // Reset mid-clear at pointer (10,3)
    d0 = done_n; c0 = clr_wr_n;
    bus.clr_start = 1'b1; bus.clr_color = 24'hF0F0F0;
    sc_tick(1'b0, '0);
    k = 0;
    while (clr_wr_n - c0 < 3*HR + 10 && k < 200) begin sc_tick(1'b0, '0); k++; end
    chk("midclear_reached", clr_wr_n - c0, 3*HR + 10);
    resetn = 1'b0;
    sc_tick(1'b0, '0);
    resetn = 1'b1;
    chk("midrst_busy", bus.clr_busy, 0);
    chk("midrst_wr_ready", bus.wr_ready, 1);
    for (int i = 0; i < 20; i++) sc_tick(1'b0, '0);
    chk("midrst_no_done", done_n - d0, 0);

    // Random mix of scanout and writes over a small address window
    for (int i = 0; i < 1500; i++) begin
      if (src.size() == 0 && $urandom_range(0, 99) < 50)
        src.push_back('{addr: 19'($urandom_range(0, 63)), data: 24'($urandom)});
      sc_tick($urandom_range(0, 99) < 50, 19'($urandom_range(0, 63)));
    end
    for (int i = 0; i < 10; i++) sc_tick(1'b0, '0);

`ifdef VMEM_ARB_STATS_EN
    for (int i = 0; i < 4; i++) src.push_back('{addr: 19'(32'h200 + i), data: 24'(i)});
    for (int i = 0; i < 70000; i++) sc_tick(1'b1, 19'(i % 64));
    chk("stat_saturated", bus.stat_stall, 16'hFFFF);
    for (int i = 0; i < 10; i++) sc_tick(1'b0, '0);
`else
    chk("stat_disabled", bus.stat_stall, 0);
`endif

    chk("final_wq_empty", wq.size(), 0);
    $display("%0d/%0d checks passed", pass_n, pass_n + fail_n);
    $finish;
  end
endmodule
